wordle_guess_eval: RTL and testbench

Sequencing controller that scores one 5-letter Wordle guess against the target word and tracks game progress. It accepts a start pulse with a packed guess, and runs a two-pass evaluation: an exact-match (green) pass, then a present-elsewhere (yellow) pass with duplicate-letter accounting. It returns per-letter colour codes plus win/lose status. It sits between the guess-entry state machine and the VGA tile renderer, and replaces ad-hoc letter comparison in the display path.

---
 rtl/wordle_guess_eval_if.sv | 24 ++
 rtl/wordle_guess_eval.sv | 163 ++++++++++++++++
 tb/tb_wordle_guess_eval.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wordle_guess_eval_if.sv
// Guess-evaluation request/result bundle between the entry FSM and the tile renderer.
interface wordle_guess_eval_if;
   logic        start;
   logic        new_game;
   logic [24:0] guess;
   logic [24:0] target;
   logic        busy;
   logic        done;
   logic [9:0]  colors;
   logic        win;
   logic        lose;
   logic [2:0]  guess_cnt;
   logic        over;

   modport master (
      output start, new_game, guess, target,
      input  busy, done, colors, win, lose, guess_cnt, over
   );

   modport slave (
      input  start, new_game, guess, target,
      output busy, done, colors, win, lose, guess_cnt, over
   );
endinterface

// File: rtl/wordle_guess_eval.sv
// Scores one 5-letter guess in two serial passes (green, then yellow with
// duplicate accounting) and tracks win/lose progress across a game.
module wordle_guess_eval #(
   parameter int unsigned MAX_GUESSES = 6
) (
   input logic               Clk,
   input logic               reset,
   wordle_guess_eval_if.slave bus
);
   typedef enum logic [2:0] {IDLE, GREEN, YELLOW, DONE, OVER} state_t;

   state_t      state;
   logic [24:0] g_q;
   logic [24:0] t_q;
   logic [4:0]  used;
   logic [2:0]  idx;
   logic [9:0]  colors_q;
   logic        busy_q;
   logic        done_q;
   logic        win_q;
   logic        lose_q;
   logic        over_q;
   logic [2:0]  cnt_q;

   logic [4:0]  g_cur;
   logic [4:0]  t_cur;
   logic [1:0]  col_cur;
   logic        hit;
   logic [2:0]  hit_j;
   logic        last;
   logic [2:0]  cnt_nxt;

   always_comb begin
      g_cur   = '0;
      t_cur   = '0;
      col_cur = '0;
      hit     = 1'b0;
      hit_j   = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (idx == 3'(i)) begin
            g_cur   = g_q[5*i +: 5];
            t_cur   = t_q[5*i +: 5];
            col_cur = colors_q[2*i +: 2];
         end
      end
      // Scan downward so the lowest matching unused position wins.
      for (int unsigned k = 0; k < 5; k++) begin
         if (!used[4-k] && t_q[5*(4-k) +: 5] == g_cur) begin
            hit   = 1'b1;
            hit_j = 3'(4 - k);
         end
      end
      last    = (idx == 3'd4);
      cnt_nxt = cnt_q + 3'd1;
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state    <= IDLE;
         g_q      <= '0;
         t_q      <= '0;
         used     <= '0;
         idx      <= '0;
         colors_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         over_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.new_game) begin
                  cnt_q    <= '0;
                  win_q    <= 1'b0;
                  lose_q   <= 1'b0;
                  colors_q <= '0;
               end else if (bus.start) begin
                  g_q      <= bus.guess;
                  t_q      <= bus.target;
                  colors_q <= '0;
                  used     <= '0;
                  idx      <= '0;
                  busy_q   <= 1'b1;
                  state    <= GREEN;
               end
            end
            GREEN: begin
               if (g_cur == t_cur) begin
                  for (int unsigned i = 0; i < 5; i++)
                     if (idx == 3'(i)) colors_q[2*i +: 2] <= 2'b10;
                  used[idx] <= 1'b1;
               end
               if (last) begin
                  idx   <= '0;
                  state <= YELLOW;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            YELLOW: begin
               if (col_cur != 2'b10 && hit) begin
                  for (int unsigned i = 0; i < 5; i++)
                     if (idx == 3'(i)) colors_q[2*i +: 2] <= 2'b01;
                  used[hit_j] <= 1'b1;
               end
               if (last) begin
                  idx    <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            DONE: begin
               cnt_q <= cnt_nxt;
               if (colors_q == 10'h2AA) begin
                  win_q  <= 1'b1;
                  over_q <= 1'b1;
                  state  <= OVER;
               end else if (cnt_nxt == 3'(MAX_GUESSES)) begin
                  lose_q <= 1'b1;
                  over_q <= 1'b1;
                  state  <= OVER;
               end else if (bus.start) begin
                  // Accepting here gives back-to-back issue at the edge after done.
                  g_q      <= bus.guess;
                  t_q      <= bus.target;
                  colors_q <= '0;
                  used     <= '0;
                  idx      <= '0;
                  busy_q   <= 1'b1;
                  state    <= GREEN;
               end else begin
                  state <= IDLE;
               end
            end
            OVER: begin
               if (bus.new_game) begin
                  cnt_q    <= '0;
                  win_q    <= 1'b0;
                  lose_q   <= 1'b0;
                  over_q   <= 1'b0;
                  colors_q <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.colors    = colors_q;
   assign bus.win       = win_q;
   assign bus.lose      = lose_q;
   assign bus.guess_cnt = cnt_q;
   assign bus.over      = over_q;
endmodule

// File: tb/tb_wordle_guess_eval.sv
// Randomized and directed bench for wordle_guess_eval against a letter-count Wordle model.
module tb_wordle_guess_eval;
   localparam int unsigned MAXG = 6;

   logic Clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   m_cnt;
   bit   m_win;
   bit   m_lose;

   wordle_guess_eval_if bus();

   wordle_guess_eval #(.MAX_GUESSES(MAXG)) dut (
      .Clk  (Clk),
      .reset(reset),
      .bus  (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [24:0] word(input string s);
      logic [24:0] w;
      w = '0;
      for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd65);
      return w;
   endfunction

   function automatic logic [24:0] rand_word(input bit narrow);
      logic [24:0] w;
      for (int i = 0; i < 5; i++) begin
         if (narrow) w[5*i +: 5] = 5'($urandom_range(0, 3));
         else if ($urandom_range(0, 9) == 0) w[5*i +: 5] = 5'(26 + $urandom_range(0, 5));
         else w[5*i +: 5] = 5'($urandom_range(0, 25));
      end
      return w;
   endfunction

   // Standard Wordle scoring: greens first, then yellows from the leftover letter counts.
   function automatic logic [9:0] ref_colors(input logic [24:0] g, input logic [24:0] t);
      int left[32];
      logic [9:0] c;
      c = '0;
      foreach (left[k]) left[k] = 0;
      for (int i = 0; i < 5; i++)
         if (g[5*i +: 5] == t[5*i +: 5]) c[2*i +: 2] = 2'b10;
         else left[t[5*i +: 5]]++;
      for (int i = 0; i < 5; i++)
         if (c[2*i +: 2] != 2'b10 && left[g[5*i +: 5]] > 0) begin
            c[2*i +: 2] = 2'b01;
            left[g[5*i +: 5]]--;
         end
      return c;
   endfunction

   task automatic run_guess(input logic [24:0] g, input logic [24:0] t, input bit pre,
                            input bit poke, input bit chain, input logic [24:0] g_next);
      logic [9:0] exp;
      exp = ref_colors(g, t);
      if (!pre) begin
         bus.guess  = g;
         bus.target = t;
         bus.start  = 1'b1;
         @(posedge Clk);
         #1;
      end
      bus.start = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge Clk);
         n_checks++;
         if (bus.busy !== (n < 11)) begin
            n_fail++;
            $display("FAIL busy cycle %0d: got %b want %b", n, bus.busy, (n < 11));
         end
         n_checks++;
         if (bus.done !== (n == 11)) begin
            n_fail++;
            $display("FAIL done cycle %0d: got %b want %b", n, bus.done, (n == 11));
         end
         if (poke && n == 2) begin
            bus.guess = ~g;
            bus.start = 1'b1;
         end
         if (poke && n == 3) bus.start = 1'b0;
         if (n == 11) begin
            n_checks++;
            if (bus.colors !== exp) begin
               n_fail++;
               $display("FAIL colors at done: got %b want %b", bus.colors, exp);
            end
            if (chain) begin
               bus.guess = g_next;
               bus.start = 1'b1;
            end
         end
      end
      m_cnt++;
      if (exp == 10'h2AA) m_win = 1'b1;
      else if (m_cnt == MAXG) m_lose = 1'b1;
      @(posedge Clk);
      #1;
      n_checks++;
      if (bus.guess_cnt !== 3'(m_cnt) || bus.win !== m_win || bus.lose !== m_lose ||
          bus.over !== (m_win | m_lose)) begin
         n_fail++;
         $display("FAIL status: got cnt=%0d win=%b lose=%b over=%b want cnt=%0d win=%b lose=%b over=%b",
                  bus.guess_cnt, bus.win, bus.lose, bus.over, m_cnt, m_win, m_lose, m_win | m_lose);
      end
      if (!chain) begin
         n_checks++;
         if (bus.colors !== exp) begin
            n_fail++;
            $display("FAIL colors hold: got %b want %b", bus.colors, exp);
         end
      end
   endtask

   task automatic new_game_pulse();
      bus.new_game = 1'b1;
      @(posedge Clk);
      #1;
      bus.new_game = 1'b0;
      m_cnt = 0;
      m_win = 1'b0;
      m_lose = 1'b0;
      n_checks++;
      if (bus.guess_cnt !== 3'd0 || bus.win !== 1'b0 || bus.lose !== 1'b0 || bus.over !== 1'b0 ||
          bus.colors !== 10'd0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL new_game clear: got cnt=%0d win=%b lose=%b over=%b colors=%b busy=%b want all zero",
                  bus.guess_cnt, bus.win, bus.lose, bus.over, bus.colors, bus.busy);
      end
   endtask

   task automatic expect_quiet(input int cycles, input string tag);
      for (int n = 0; n < cycles; n++) begin
         @(negedge Clk);
         n_checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got busy=%b done=%b want 0 0", tag, n, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.new_game = 1'b0;
      bus.guess = '0;
      bus.target = '0;
      repeat (2) @(posedge Clk);
      #1;
      reset = 1'b0;
      m_cnt = 0;
      m_win = 1'b0;
      m_lose = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.colors !== 10'd0 || bus.win !== 1'b0 ||
          bus.lose !== 1'b0 || bus.guess_cnt !== 3'd0 || bus.over !== 1'b0) begin
         n_fail++;
         $display("FAIL reset values: got busy=%b done=%b colors=%b win=%b lose=%b cnt=%0d over=%b want all zero",
                  bus.busy, bus.done, bus.colors, bus.win, bus.lose, bus.guess_cnt, bus.over);
      end
   endtask

   task automatic test_exact_match();
      new_game_pulse();
      run_guess(word("CRANE"), word("CRANE"), 1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (bus.colors !== 10'h2AA || bus.win !== 1'b1 || bus.guess_cnt !== 3'd1 || bus.over !== 1'b1) begin
         n_fail++;
         $display("FAIL exact_match: got colors=%h win=%b cnt=%0d over=%b want 2aa 1 1 1",
                  bus.colors, bus.win, bus.guess_cnt, bus.over);
      end
      bus.guess = word("BOBBY");
      bus.start = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      expect_quiet(13, "start_in_over");
      n_checks++;
      if (bus.guess_cnt !== 3'd1) begin
         n_fail++;
         $display("FAIL start_in_over cnt: got %0d want 1", bus.guess_cnt);
      end
   endtask

   task automatic test_duplicates();
      new_game_pulse();
      run_guess(word("BOBBY"), word("ABBEY"), 1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (bus.colors !== 10'b1000100001 || bus.win !== 1'b0 || bus.guess_cnt !== 3'd1 || bus.over !== 1'b0) begin
         n_fail++;
         $display("FAIL duplicates: got colors=%b win=%b cnt=%0d over=%b want 1000100001 0 1 0",
                  bus.colors, bus.win, bus.guess_cnt, bus.over);
      end
   endtask

   task automatic test_lose();
      string miss[6] = '{"BOBBY", "FIGHT", "JUMPS", "WOUND", "SLICK", "PLAZA"};
      new_game_pulse();
      foreach (miss[i]) run_guess(word(miss[i]), word("CRANE"), 1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (bus.lose !== 1'b1 || bus.over !== 1'b1 || bus.guess_cnt !== 3'd6 || bus.win !== 1'b0) begin
         n_fail++;
         $display("FAIL lose: got lose=%b over=%b cnt=%0d win=%b want 1 1 6 0",
                  bus.lose, bus.over, bus.guess_cnt, bus.win);
      end
      bus.guess = word("CRANE");
      bus.start = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      expect_quiet(13, "seventh_start");
      new_game_pulse();
   endtask

   task automatic test_win_third();
      new_game_pulse();
      run_guess(word("SLATE"), word("MOIST"), 1'b0, 1'b0, 1'b0, '0);
      run_guess(word("POINT"), word("MOIST"), 1'b0, 1'b0, 1'b0, '0);
      run_guess(word("MOIST"), word("MOIST"), 1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (bus.win !== 1'b1 || bus.guess_cnt !== 3'd3 || bus.lose !== 1'b0) begin
         n_fail++;
         $display("FAIL win_third: got win=%b cnt=%0d lose=%b want 1 3 0", bus.win, bus.guess_cnt, bus.lose);
      end
   endtask

   task automatic test_new_game_priority();
      new_game_pulse();
      run_guess(word("BOBBY"), word("CRANE"), 1'b0, 1'b0, 1'b0, '0);
      bus.start = 1'b1;
      bus.new_game = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      bus.new_game = 1'b0;
      m_cnt = 0;
      expect_quiet(13, "newgame_beats_start");
      n_checks++;
      if (bus.guess_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL newgame_beats_start cnt: got %0d want 0", bus.guess_cnt);
      end
   endtask

   task automatic test_mid_reset();
      new_game_pulse();
      run_guess(word("PLAZA"), word("CRANE"), 1'b0, 1'b0, 1'b0, '0);
      bus.guess = word("CRANE");
      bus.start = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(negedge Clk);
      reset = 1'b1;
      @(posedge Clk);
      #1;
      reset = 1'b0;
      m_cnt = 0;
      m_win = 1'b0;
      m_lose = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.colors !== 10'd0 || bus.win !== 1'b0 ||
          bus.lose !== 1'b0 || bus.guess_cnt !== 3'd0 || bus.over !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got busy=%b done=%b colors=%b win=%b lose=%b cnt=%0d over=%b want all zero",
                  bus.busy, bus.done, bus.colors, bus.win, bus.lose, bus.guess_cnt, bus.over);
      end
      expect_quiet(14, "after_mid_reset");
   endtask

   task automatic test_isolation();
      logic [24:0] t;
      new_game_pulse();
      t = rand_word(1'b1);
      run_guess(rand_word(1'b1), t, 1'b0, 1'b1, 1'b0, '0);
      expect_quiet(12, "isolation_single_done");
   endtask

   task automatic test_back_to_back();
      logic [24:0] t;
      logic [24:0] g1;
      logic [24:0] g2;
      logic [24:0] g3;
      new_game_pulse();
      t = rand_word(1'b1);
      do g1 = rand_word(1'b1); while (g1 == t);
      do g2 = rand_word(1'b1); while (g2 == t);
      do g3 = rand_word(1'b1); while (g3 == t);
      run_guess(g1, t, 1'b0, 1'b0, 1'b1, g2);
      run_guess(g2, t, 1'b1, 1'b0, 1'b1, g3);
      run_guess(g3, t, 1'b1, 1'b0, 1'b0, '0);
   endtask

   task automatic test_random();
      logic [24:0] t;
      logic [24:0] g;
      bit narrow;
      for (int game = 0; game < 8; game++) begin
         new_game_pulse();
         narrow = game[0];
         t = rand_word(narrow);
         while (!(m_win || m_lose)) begin
            g = ($urandom_range(0, 4) == 0) ? t : rand_word(narrow);
            run_guess(g, t, 1'b0, 1'b0, 1'b0, '0);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_exact_match();
      test_duplicates();
      test_lose();
      test_win_third();
      test_new_game_priority();
      test_mid_reset();
      test_isolation();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
